// File: rtl/rv32_mem_map.sv
// Shared memory-map definitions for the RV32 data-side responder and any
// later peripherals that live in the same MMIO page.
package rv32_mem_map;

    // Default region bases
    localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'h1000_0000;

    // MMIO register offsets within the 16-byte page
    localparam logic [3:0] MMIO_TX     = 4'h0;
    localparam logic [3:0] MMIO_STATUS = 4'h4;
    localparam logic [3:0] MMIO_CYCLE  = 4'h8;

    // STATUS register bit positions
    localparam int ST_ERR   = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a head-of-queue output, shared by the
// console path and future byte-stream peripherals. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array: only the occupied slots are ever read, so it carries no reset.
    // NOTE: memories are left out of reset so they map onto plain RAM cells; the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder for the single-cycle RV32 core: word RAM with
// same-cycle reads plus a 16-byte MMIO page (console TX FIFO, STATUS,
// free-running CYCLE counter). Bad accesses are suppressed and flagged.
module rv32_dmem_responder
    import rv32_mem_map::*;
#(
    parameter int              AW         = 32,
    parameter int              DW         = 32,
    parameter int              RAM_WORDS  = 1024,
    parameter logic [AW-1:0]   RAM_BASE   = DEF_RAM_BASE,
    parameter logic [AW-1:0]   MMIO_BASE  = DEF_MMIO_BASE,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] address,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [7:0]    console_data,
    output logic          console_valid,
    input  logic          console_ready,
    output logic          err
);

    localparam int            RAM_AW    = $clog2(RAM_WORDS);
    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [AW-1:0] RAM_MASK  = AW'(4 * RAM_WORDS - 1);
    localparam logic [AW-1:0] MMIO_MASK = AW'(15);

    logic [DW-1:0]     mem [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic [3:0]        offset;
    logic              ram_hit;
    logic              mmio_hit;
    logic              misaligned;
    logic              bad_access;
    logic              write_ok;
    logic              ram_we;
    logic              mmio_we;
    logic              tx_push;
    logic              status_we;
    logic              cycle_we;
    logic              pop_fire;
    logic              tx_drop;
    logic              overflow;
    logic [DW-1:0]     cycle_cnt;
    logic [3:0]        status_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // Address decode; both regions are size-aligned so a masked compare suffices.
    assign ram_hit    = (address & ~RAM_MASK) == RAM_BASE;
    assign mmio_hit   = (address & ~MMIO_MASK) == MMIO_BASE;
    assign misaligned = (address[1:0] != 2'b00);
    assign ram_idx    = address[RAM_AW+1:2];
    assign offset     = address[3:0];
    assign bad_access = (MemRead || MemWrite) && (misaligned || !(ram_hit || mmio_hit));

    // Writes are qualified by alignment and ignored while reset is asserted.
    assign write_ok  = MemWrite && reset_n && !misaligned;
    assign ram_we    = write_ok && ram_hit;
    assign mmio_we   = write_ok && mmio_hit;
    assign tx_push   = mmio_we && (offset == MMIO_TX);
    assign status_we = mmio_we && (offset == MMIO_STATUS);
    assign cycle_we  = mmio_we && (offset == MMIO_CYCLE);

    assign pop_fire      = console_valid && console_ready;
    assign console_valid = !fifo_empty;
    assign tx_drop       = tx_push && (fifo_count == CW'(FIFO_DEPTH)) && !pop_fire;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (tx_push),
        .push_data (wdata[7:0]),
        .pop       (pop_fire),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (console_data)
    );

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= wdata;
        end
    end

    // Free-running cycle counter, overridden by a CYCLE write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
        end else if (cycle_we) begin
            cycle_cnt <= wdata;
        end else begin
            cycle_cnt <= cycle_cnt + DW'(1);
        end
    end

    // Sticky flags: a new error in the same cycle beats a W1C clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (bad_access) begin
                err <= 1'b1;
            end else if (status_we && wdata[ST_ERR]) begin
                err <= 1'b0;
            end
            if (tx_drop) begin
                overflow <= 1'b1;
            end else if (status_we && wdata[ST_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    // STATUS word assembly by named bit position.
    always_comb begin
        status_word           = '0;
        status_word[ST_ERR]   = err;
        status_word[ST_EMPTY] = fifo_empty;
        status_word[ST_FULL]  = fifo_full;
        status_word[ST_OVF]   = overflow;
    end

    // Combinational read mux; suppressed and idle reads return zero.
    // NOTE: rdata gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        rdata = '0;
        if (MemRead && !misaligned) begin
            if (ram_hit) begin
                rdata = mem[ram_idx];
            end else if (mmio_hit) begin
                case (offset)
                    MMIO_STATUS: rdata = DW'(status_word);
                    MMIO_CYCLE:  rdata = cycle_cnt;
                    default:     rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed self-checking bench for rv32_dmem_responder: a vector table for
// single-access behaviour plus hand-written FIFO, counter and reset sequences.
module tb_rv32_dmem_responder;

    localparam logic [31:0] TX     = 32'h1000_0000;
    localparam logic [31:0] STATUS = 32'h1000_0004;
    localparam logic [31:0] CYCLE  = 32'h1000_0008;
    localparam logic [31:0] RSVD   = 32'h1000_000C;

    logic        clk;
    logic        reset_n;
    logic [31:0] address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  console_data;
    logic        console_valid;
    logic        console_ready;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    rv32_dmem_responder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .wdata         (wdata),
        .rdata         (rdata),
        .console_data  (console_data),
        .console_valid (console_valid),
        .console_ready (console_ready),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        MemRead  = rd;
        MemWrite = wr;
        address  = a;
        wdata    = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input string n, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.data = d;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] c0;

        console_ready = 1'b0;
        idle();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Reset state
        check("rst_err", 32'(err), 32'h0);
        check("rst_valid", 32'(console_valid), 32'h0);
        check("rst_data", 32'(console_data), 32'h0);
        drive(1'b1, 1'b0, CYCLE, 32'h0);
        #1;
        check("rst_cycle", rdata, 32'h0);
        tick();

        // Table: rdata checked before the edge, err checked after it
        add("ram_wr10",     0, 1, 32'h10,        32'hDEADBEEF, 32'h0,        0);
        add("ram_rd10",     1, 0, 32'h10,        32'h0,        32'hDEADBEEF, 0);
        add("ram_wr14",     0, 1, 32'h14,        32'h12345678, 32'h0,        0);
        add("ram_rd14",     1, 0, 32'h14,        32'h0,        32'h12345678, 0);
        add("ram_wr10_1",   0, 1, 32'h10,        32'h1,        32'h0,        0);
        add("rbw_old",      1, 1, 32'h10,        32'h2,        32'h1,        0);
        add("rbw_new",      1, 0, 32'h10,        32'h0,        32'h2,        0);
        add("nord_zero",    0, 0, 32'h10,        32'h0,        32'h0,        0);
        add("ram_wr0",      0, 1, 32'h0,         32'h11111111, 32'h0,        0);
        add("ram_wr_last",  0, 1, 32'hFFC,       32'hCAFEF00D, 32'h0,        0);
        add("ram_rd_last",  1, 0, 32'hFFC,       32'h0,        32'hCAFEF00D, 0);
        add("rsvd_rd",      1, 0, RSVD,          32'h0,        32'h0,        0);
        add("rsvd_wr",      0, 1, RSVD,          32'hFFFFFFFF, 32'h0,        0);
        add("status_idle",  1, 0, STATUS,        32'h0,        32'h2,        0);
        add("tx_rd",        1, 0, TX,            32'h0,        32'h0,        0);
        add("unmap_rd",     1, 0, 32'h2000_0000, 32'h0,        32'h0,        1);
        add("status_err",   1, 0, STATUS,        32'h0,        32'h3,        1);
        add("w1c_err",      0, 1, STATUS,        32'h1,        32'h0,        0);
        add("misal_wr",     0, 1, 32'h2,         32'h5,        32'h0,        1);
        add("w1c_err2",     0, 1, STATUS,        32'h1,        32'h0,        0);
        add("ram0_intact",  1, 0, 32'h0,         32'h0,        32'h11111111, 0);
        add("misal_rd",     1, 0, 32'h11,        32'h0,        32'h0,        1);
        add("w1c_9",        0, 1, STATUS,        32'h9,        32'h0,        0);
        add("past_ram_rd",  1, 0, 32'h1000,      32'h0,        32'h0,        1);
        add("rbw_status",   1, 1, STATUS,        32'h1,        32'h3,        0);
        add("below_mmio",   1, 0, 32'h0FFF_FFFC, 32'h0,        32'h0,        1);
        add("w1c_final",    0, 1, STATUS,        32'h1,        32'h0,        0);

        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
            #1;
            check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            tick();
            check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
        end
        idle();

        // FIFO overflow: five pushes with the sink stalled
        console_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, TX, 32'(8'h41 + i));
            tick();
        end
        drive(1'b1, 1'b0, STATUS, 32'h0);
        #1;
        check("ovf_status", rdata, 32'hC);
        check("ovf_head", 32'(console_data), 32'h41);
        check("ovf_err", 32'(err), 32'h0);
        idle();

        // Drain: A..D on consecutive cycles, then empty
        console_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", 32'(console_valid), 32'h1);
            check("drain_data", 32'(console_data), 32'(8'h41 + i));
            tick();
        end
        check("drain_done_valid", 32'(console_valid), 32'h0);
        check("drain_done_data", 32'(console_data), 32'h0);
        console_ready = 1'b0;

        drive(1'b0, 1'b1, STATUS, 32'h8);
        tick();
        drive(1'b1, 1'b0, STATUS, 32'h0);
        #1;
        check("ovf_cleared", rdata, 32'h2);
        idle();

        // Push while full with a simultaneous pop
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, TX, 32'(8'h31 + i));
            tick();
        end
        console_ready = 1'b1;
        drive(1'b0, 1'b1, TX, 32'h58);
        #1;
        check("pp_head", 32'(console_data), 32'h31);
        tick();
        console_ready = 1'b0;
        drive(1'b1, 1'b0, STATUS, 32'h0);
        #1;
        check("pp_status", rdata, 32'h4);
        idle();
        console_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 3) ? 8'h58 : 8'(8'h32 + i);
            #1;
            check("pp_drain", 32'(console_data), 32'(exp_b));
            tick();
        end
        check("pp_empty", 32'(console_valid), 32'h0);
        console_ready = 1'b0;

        // CYCLE load and wrap
        drive(1'b0, 1'b1, CYCLE, 32'hFFFF_FFFE);
        tick();
        drive(1'b1, 1'b0, CYCLE, 32'h0);
        #1;
        check("cyc_load", rdata, 32'hFFFF_FFFE);
        tick();
        check("cyc_plus1", rdata, 32'hFFFF_FFFF);
        tick();
        check("cyc_wrap", rdata, 32'h0);
        tick();
        c0 = rdata;
        tick();
        check("cyc_step", rdata, c0 + 32'h1);
        idle();

        // Reset asserted mid-drain with dirty state
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, TX, 32'(8'h61 + i));
            tick();
        end
        drive(1'b1, 1'b0, 32'h3000_0000, 32'h0);
        tick();
        check("pre_rst_err", 32'(err), 32'h1);
        drive(1'b0, 1'b1, CYCLE, 32'd100);
        tick();
        idle();
        console_ready = 1'b1;
        tick();
        reset_n = 1'b0;
        console_ready = 1'b0;
        drive(1'b0, 1'b1, TX, 32'h5A);
        tick();
        reset_n = 1'b1;
        drive(1'b1, 1'b0, CYCLE, 32'h0);
        #1;
        check("rst2_valid", 32'(console_valid), 32'h0);
        check("rst2_data", 32'(console_data), 32'h0);
        check("rst2_err", 32'(err), 32'h0);
        check("rst2_cycle", rdata, 32'h0);
        tick();
        check("rst2_cycle1", rdata, 32'h1);
        drive(1'b1, 1'b0, STATUS, 32'h0);
        #1;
        check("rst2_status", rdata, 32'h2);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_dmem_responder.md
# rv32_dmem_responder

Data-side responder for the RV32 single-cycle core: terminates the core's `address/MemRead/MemWrite/wdata/rdata` data-memory interface. It provides a word-addressed data RAM with same-cycle read and a small MMIO page. The MMIO page holds a buffered console-output FIFO with a valid/ready drain port, a free-running cycle counter, and sticky error/status flags. It sits beside the core in the SoC top, alongside the instruction ROM.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; fixed at 32.
- `RAM_WORDS`, 1024, RAM depth in 32-bit words; power of two.
- `RAM_BASE`, 32'h0000_0000, RAM region base; aligned to 4*RAM_WORDS.
- `MMIO_BASE`, 32'h1000_0000, MMIO page base; 16-byte page.
- `FIFO_DEPTH`, 4, console FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `address` in AW: byte address from the core.
- `MemRead` in 1: read strobe.
- `MemWrite` in 1: write strobe.
- `wdata` in DW: store data.
- `rdata` out DW: load data, combinational.
- `console_data` out 8: FIFO head byte.
- `console_valid` out 1: FIFO non-empty.
- `console_ready` in 1: sink accepts the head byte.
- `err` out 1: sticky access error.

## Operation
- Decode:
  - RAM hit: `address` in [RAM_BASE, RAM_BASE+4*RAM_WORDS).
  - MMIO hit: `address` in [MMIO_BASE, MMIO_BASE+16).
  - Anything else is unmapped.
- Misaligned access (`address[1:0]!=0`) with either strobe active:
  - The access is suppressed: no write, `rdata`=0.
  - `err` is set.
- Unmapped access with either strobe active:
  - The access is suppressed and `err` is set.
  - A read returns 0.
- RAM:
  - Read: `rdata`=mem[address[log2(RAM_WORDS)+1:2]] when `MemRead` is high.
  - Write: mem written at the posedge when `MemWrite` is high.
  - RAM contents are not reset.
- MMIO offsets:
  - 0x0 TX. Write pushes `wdata[7:0]` into the FIFO. Read returns 0.
  - 0x4 STATUS. Read returns {28'b0, overflow, full, empty, err}. Write is W1C: bit0 clears `err`, bit3 clears overflow.
  - 0x8 CYCLE. Read returns the counter. Write loads the counter with `wdata`.
  - 0xC. Reserved: reads 0, writes ignored, no error.
- `rdata`=0 whenever `MemRead` is low.
- `MemRead` and `MemWrite` high together: the write takes effect at the edge; `rdata` shows pre-write contents (read-before-write).
- FIFO:
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - A push into a full FIFO with no pop is dropped and sets overflow (sticky).
  - Pop occurs when `console_valid && console_ready`.
  - Count range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
  - `console_data`=0 when empty.
- Cycle counter: increments by 1 every cycle and wraps 32'hFFFF_FFFF→0. A CYCLE write overrides the increment for that edge.
- Error clear vs. new error in the same cycle: the new error wins and `err` stays 1.

## Timing
- Reset, sampled at posedge while `reset_n`=0:
  - Counter=0, FIFO empty, `err`=0, overflow=0.
  - `console_valid`=0, `console_data`=0.
  - Register writes are ignored during reset.
- `rdata` has zero latency: combinational from `address`/`MemRead` and the current state.
- Write visibility:
  - A RAM or MMIO write at edge N is visible to reads in cycle N+1.
  - A TX write at edge N raises `console_valid` in cycle N+1.
- CYCLE:
  - A write of V at edge N reads V in cycle N+1 and V+1 in cycle N+2.
  - Without writes, back-to-back reads differ by exactly 1.
- FIFO:
  - A pop at edge N advances `console_data` in cycle N+1.
  - Simultaneous push and pop leaves the count unchanged.
- Reset asserted mid-drain: the FIFO empties at that edge, and `console_valid` drops in the next cycle regardless of `console_ready`.

## Structure
- Shared package `rv32_mem_map`:
  - MMIO offset constants (TX, STATUS, CYCLE).
  - STATUS bit positions.
  - Default RAM_BASE/MMIO_BASE.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - Ports: push/pop/full/empty/count/head.
  - Synchronous active-low reset.
  - Reused for later peripherals.
- Top-level logic: decode, RAM array, counter, status flags, read mux.

## Test plan
- RAM write/read: write 32'hDEADBEEF to 0x0000_0010, then read it → `rdata`=32'hDEADBEEF next cycle. Read 0x0000_0014 with no prior write → `err` stays 0.
- Read-before-write: MemRead=MemWrite=1 at 0x10 (old value 1, new value 2) → `rdata`=1 in that cycle and 2 in the next.
- FIFO:
  - With `console_ready`=0, push 'A','B','C','D','E' → STATUS reads full=1, overflow=1.
  - Then raise `console_ready` → 'A','B','C','D' drain on consecutive cycles, then `console_valid`=0.
- Simultaneous push and pop with full FIFO: push 'X' while a pop occurs → count stays 4, no overflow, and 'X' emerges last.
- Errors:
  - Read 0x2000_0000 → `rdata`=0, `err`=1.
  - Write 0x0000_0002 → RAM unchanged, `err`=1.
  - Write STATUS 32'h9 → `err`=0 and overflow=0 next cycle.
- Counter and reset: write CYCLE=32'hFFFF_FFFE, then read on two later cycles → 32'hFFFF_FFFF, then 0. Assert `reset_n` mid-drain → counter=0, `console_valid`=0, `err`=0 on the next cycle.
